// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with HI/LO registers and pipeline stall generation
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MDInD,
  output logic        Busy,
  output logic        StallMD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s;
  logic [63:0] prod_s, prod_u, res;
  logic is_long, div_zero;
  assign is_long  = Start && MDUOp >= 4'd1 && MDUOp <= 4'd4;
  assign prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u   = {32'b0, a_q} * {32'b0, b_q};
  // signed division via magnitudes so INT_MIN/-1 wraps instead of trapping
  assign a_mag    = a_q[31] ? -a_q : a_q;
  assign b_mag    = b_q[31] ? -b_q : b_q;
  assign q_mag    = a_mag / b_mag;
  assign r_mag    = a_mag % b_mag;
  assign q_s      = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
  assign r_s      = a_q[31] ? -r_mag : r_mag;
  assign res      = op_q == 3'd1 ? prod_s : op_q == 3'd2 ? prod_u :
                    op_q == 3'd3 ? {r_s, q_s} : {a_q % b_q, a_q / b_q};
  assign div_zero = op_q >= 3'd3 && b_q == 32'd0;
  assign Busy     = state_q == BUSY;
  assign StallMD  = MDInD & (Busy | is_long);
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign MDOut    = MDUOp == 4'd5 ? hi_q : MDUOp == 4'd6 ? lo_q : 32'd0;
  // accept ops in IDLE, count down in BUSY and commit the result on the last busy edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == IDLE) begin
      if (is_long) begin
        state_d = BUSY;
        cnt_d   = MDUOp <= 4'd2 ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        op_d    = MDUOp[2:0];
        a_d     = A;
        b_d     = B;
      end else if (Start && MDUOp == 4'd7) hi_d = A;
      else if (Start && MDUOp == 4'd8) lo_d = A;
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        if (!div_zero) {hi_d, lo_d} = res;
      end
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against a behavioural model
module tb_mdu_ctrl;
  logic clk = 1'b0, reset = 1'b0, Start = 1'b0, MDInD = 1'b0;
  logic [3:0] MDUOp = 4'd0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic Busy, StallMD;
  logic [31:0] HI, LO, MDOut;
  int checks = 0, failures = 0;

  mdu_ctrl dut (.clk(clk), .reset(reset), .MDUOp(MDUOp), .Start(Start), .A(A), .B(B),
                .MDInD(MDInD), .Busy(Busy), .StallMD(StallMD), .HI(HI), .LO(LO), .MDOut(MDOut));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: remaining busy cycles plus the pending {write, HI, LO} computed with 64-bit arithmetic
  int m_left = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [64:0] m_pend = 65'd0;

  function automatic logic [64:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == 4'd1) begin p = 64'(sa * sb); return {1'b1, p}; end
    if (op == 4'd2) begin p = ua * ub; return {1'b1, p}; end
    if (b == 32'd0) return 65'd0;
    if (op == 4'd3) begin
      q = sa / sb;
      r = sa % sb;
      return {1'b1, r[31:0], q[31:0]};
    end
    p = ua / ub;
    q = longint'(ua % ub);
    return {1'b1, q[31:0], p[31:0]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_pend <= 65'd0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_pend[64]) {m_hi, m_lo} <= m_pend[63:0];
    end else if (Start && MDUOp >= 4'd1 && MDUOp <= 4'd4) begin
      m_pend <= calc(MDUOp, A, B);
      m_left <= MDUOp <= 4'd2 ? 5 : 10;
    end else if (Start && MDUOp == 4'd7) m_hi <= A;
    else if (Start && MDUOp == 4'd8) m_lo <= A;
  end

  // compare every cycle away from the active edge
  always @(negedge clk) begin
    logic mb;
    mb = m_left > 0;
    chk("busy", {31'd0, Busy}, {31'd0, mb});
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    chk("stall", {31'd0, StallMD}, {31'd0, MDInD & (mb | (Start & MDUOp >= 4'd1 & MDUOp <= 4'd4))});
    chk("mdout", MDOut, MDUOp == 4'd5 ? m_hi : MDUOp == 4'd6 ? m_lo : 32'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    Start = 1'b1; MDUOp = op; A = a; B = b;
    tick;
    Start = 1'b0; MDUOp = 4'd0;
    n = 0;
    while (Busy && n < 50) begin n++; tick; end
  endtask

  initial begin
    int n;
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    tick;
    reset = 1'b0;
    tick;
    run_op(4'd1, 32'hFFFFFFFE, 32'd3, n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);
    MDUOp = 4'd5;
    #1 chk("mfhi", MDOut, 32'hFFFFFFFF);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, n);
    chk("div_cycles", n, 32'd10);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);
    run_op(4'd4, 32'hFFFFFFF9, 32'd2, n);
    chk("divu_lo", LO, 32'h7FFFFFFC);
    chk("divu_hi", HI, 32'd1);
    Start = 1'b1; MDUOp = 4'd7; A = 32'h12345678;
    tick;
    chk("mthi", HI, 32'h12345678);
    run_op(4'd4, 32'd55, 32'd0, n);
    chk("div0_cycles", n, 32'd10);
    chk("div0_hi", HI, 32'h12345678);
    chk("div0_lo", LO, 32'h7FFFFFFC);
    Start = 1'b1; MDUOp = 4'd2; A = 32'd9; B = 32'd9; MDInD = 1'b1;
    #1 chk("stall_start", {31'd0, StallMD}, 32'd1);
    tick;
    Start = 1'b0; MDUOp = 4'd0;
    n = 0;
    while (Busy && n < 50) begin chk("stall_busy", {31'd0, StallMD}, 32'd1); n++; tick; end
    chk("stall_cycles", n, 32'd5);
    chk("stall_end", {31'd0, StallMD}, 32'd0);
    MDInD = 1'b0;
    Start = 1'b1; MDUOp = 4'd1; A = 32'd7; B = 32'd6;
    tick;
    MDUOp = 4'd1; A = 32'd100; B = 32'd100;
    tick;
    MDUOp = 4'd8; A = 32'hDEAD;
    tick;
    Start = 1'b0; MDUOp = 4'd0;
    n = 2;
    while (Busy && n < 50) begin n++; tick; end
    chk("ign_cycles", n, 32'd5);
    chk("ign_lo", LO, 32'd42);
    chk("ign_hi", HI, 32'd0);
    Start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd7;
    tick;
    Start = 1'b0; MDUOp = 4'd0;
    tick;
    tick;
    #3 reset = 1'b1;
    #1;
    chk("mid_busy", {31'd0, Busy}, 32'd0);
    chk("mid_hi", HI, 32'd0);
    chk("mid_lo", LO, 32'd0);
    #3 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("post_busy", {31'd0, Busy}, 32'd0);
      chk("post_hilo", HI | LO, 32'd0);
    end
    for (int i = 0; i < 600; i++) begin
      Start = $urandom_range(0, 9) < 7;
      MDUOp = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      A = $urandom_range(0, 15) == 0 ? 32'h80000000 : $urandom;
      B = $urandom_range(0, 9) == 0 ? 32'd0 : $urandom_range(0, 9) == 0 ? 32'hFFFFFFFF :
          $urandom_range(0, 1) == 0 ? 32'($urandom_range(1, 300)) : $urandom;
      MDInD = 1'($urandom_range(0, 1));
      tick;
    end
    Start = 1'b0;
    MDUOp = 4'd0;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
